// File: rtl/morse_sequencer.sv
// Morse LED transmitter for letters A-Z: unit-timed marks/spaces, single-shot or repeat, stop abort.
// Outputs registered, one cycle after the deciding edge; no backpressure, start ignored while busy.
module morse_sequencer #(
   parameter int CLK_HZ     = 50000000,
   parameter int UNIT_HZ    = 2,
   parameter int DASH_UNITS = 3,
   parameter int GAP_UNITS  = 3
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [4:0] letter,
   input  logic       start,
   input  logic       repeat_mode,
   input  logic       stop,
   output logic       led,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam int DIV  = CLK_HZ / UNIT_HZ;
   localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int MAXU = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
   localparam int UW   = $clog2(MAXU + 1);

   typedef enum logic [2:0] {IDLE, MARK, SPACE, GAP, DONE} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [UW-1:0]   units, units_n, load_units;
   logic [1:0]      idx, idx_n, nxt_idx;
   logic [2:0]      len_q, len_n, rom_len;
   logic [3:0]      sym_q, sym_n, rom_sym, sh;
   logic            err_n, tick, valid, last_sym;

   // Symbols are left-aligned: the first symbol sits in bit 3, 1 = dash.
   always_comb begin
      rom_len = 3'd0;
      rom_sym = 4'b0000;
      case (letter)
         5'd0:  begin rom_len = 3'd2; rom_sym = 4'b0100; end
         5'd1:  begin rom_len = 3'd4; rom_sym = 4'b1000; end
         5'd2:  begin rom_len = 3'd4; rom_sym = 4'b1010; end
         5'd3:  begin rom_len = 3'd3; rom_sym = 4'b1000; end
         5'd4:  begin rom_len = 3'd1; rom_sym = 4'b0000; end
         5'd5:  begin rom_len = 3'd4; rom_sym = 4'b0010; end
         5'd6:  begin rom_len = 3'd3; rom_sym = 4'b1100; end
         5'd7:  begin rom_len = 3'd4; rom_sym = 4'b0000; end
         5'd8:  begin rom_len = 3'd2; rom_sym = 4'b0000; end
         5'd9:  begin rom_len = 3'd4; rom_sym = 4'b0111; end
         5'd10: begin rom_len = 3'd3; rom_sym = 4'b1010; end
         5'd11: begin rom_len = 3'd4; rom_sym = 4'b0100; end
         5'd12: begin rom_len = 3'd2; rom_sym = 4'b1100; end
         5'd13: begin rom_len = 3'd2; rom_sym = 4'b1000; end
         5'd14: begin rom_len = 3'd3; rom_sym = 4'b1110; end
         5'd15: begin rom_len = 3'd4; rom_sym = 4'b0110; end
         5'd16: begin rom_len = 3'd4; rom_sym = 4'b1101; end
         5'd17: begin rom_len = 3'd3; rom_sym = 4'b0100; end
         5'd18: begin rom_len = 3'd3; rom_sym = 4'b0000; end
         5'd19: begin rom_len = 3'd1; rom_sym = 4'b1000; end
         5'd20: begin rom_len = 3'd3; rom_sym = 4'b0010; end
         5'd21: begin rom_len = 3'd4; rom_sym = 4'b0001; end
         5'd22: begin rom_len = 3'd3; rom_sym = 4'b0110; end
         5'd23: begin rom_len = 3'd4; rom_sym = 4'b1001; end
         5'd24: begin rom_len = 3'd4; rom_sym = 4'b1011; end
         5'd25: begin rom_len = 3'd4; rom_sym = 4'b1100; end
         default: begin rom_len = 3'd0; rom_sym = 4'b0000; end
      endcase
   end

   assign valid      = (letter <= 5'd25);
   assign tick       = (cnt == CW'(DIV - 1));
   assign nxt_idx    = idx + 2'd1;
   assign last_sym   = (({1'b0, idx} + 3'd1) == len_q);
   assign sh         = sym_q << nxt_idx;
   assign load_units = rom_sym[3] ? UW'(DASH_UNITS) : UW'(1);

   always_comb begin
      state_n = state;
      cnt_n   = tick ? '0 : cnt + CW'(1);
      units_n = units;
      idx_n   = idx;
      len_n   = len_q;
      sym_n   = sym_q;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (start && !stop) begin
               if (valid) begin
                  len_n   = rom_len;
                  sym_n   = rom_sym;
                  idx_n   = 2'd0;
                  units_n = load_units;
                  state_n = MARK;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         MARK: if (tick) begin
            if (units == UW'(1)) begin
               if (!last_sym) begin
                  state_n = SPACE;
                  units_n = UW'(1);
               end else if (repeat_mode) begin
                  state_n = GAP;
                  units_n = UW'(GAP_UNITS);
               end else begin
                  state_n = DONE;
               end
            end else begin
               units_n = units - UW'(1);
            end
         end
         SPACE: if (tick) begin
            if (units == UW'(1)) begin
               idx_n   = nxt_idx;
               units_n = sh[3] ? UW'(DASH_UNITS) : UW'(1);
               state_n = MARK;
            end else begin
               units_n = units - UW'(1);
            end
         end
         GAP: if (tick) begin
            if (units == UW'(1)) begin
               if (valid) begin
                  len_n   = rom_len;
                  sym_n   = rom_sym;
                  idx_n   = 2'd0;
                  units_n = load_units;
                  state_n = MARK;
               end else begin
                  err_n   = 1'b1;
                  state_n = IDLE;
               end
            end else begin
               units_n = units - UW'(1);
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Abort wins over any in-flight transition, including a pending err.
      if (stop && state != IDLE) begin
         state_n = IDLE;
         err_n   = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         units <= '0;
         idx   <= 2'd0;
         len_q <= 3'd0;
         sym_q <= 4'd0;
         led   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         units <= units_n;
         idx   <= idx_n;
         len_q <= len_n;
         sym_q <= sym_n;
         led   <= (state_n == MARK);
         busy  <= (state_n == MARK) || (state_n == SPACE) || (state_n == GAP);
         done  <= (state_n == DONE);
         err   <= err_n;
      end
   end
endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: directed scenarios then random stimulus, checked against a
// waveform-queue model that expands each letter into its expected per-cycle LED levels.
module tb_morse_sequencer;
   localparam int CLK_HZ  = 8;
   localparam int UNIT_HZ = 2;
   localparam int DIV     = CLK_HZ / UNIT_HZ;
   localparam int DASH    = 3;
   localparam int GAPU    = 3;

   logic       CLOCK_50 = 1'b0;
   logic       resetn = 1'b0;
   logic [4:0] letter = 5'd0;
   logic       start = 1'b0;
   logic       rpt = 1'b0;
   logic       stop = 1'b0;
   logic       led, busy, done, err;

   int n_vec = 0;
   int n_bad = 0;

   morse_sequencer #(.CLK_HZ(CLK_HZ), .UNIT_HZ(UNIT_HZ), .DASH_UNITS(DASH), .GAP_UNITS(GAPU)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .letter(letter), .start(start),
      .repeat_mode(rpt), .stop(stop), .led(led), .busy(busy), .done(done), .err(err)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   string codes [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--.."};

   // Model: m_state 0 = idle, 1 = sending (q holds remaining LED levels, front = this cycle), 2 = done.
   int  m_state = 0;
   bit  q[$];
   bit  in_gap = 1'b0;
   bit  exp_err = 1'b0;

   task automatic chk(input string tag, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %b, expected %b at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_load(input int l);
      string s;
      s = codes[l];
      q.delete();
      in_gap = 1'b0;
      for (int k = 0; k < s.len(); k++) begin
         if (k > 0) repeat (DIV) q.push_back(1'b0);
         repeat ((s[k] == "-") ? DASH * DIV : DIV) q.push_back(1'b1);
      end
   endtask

   task automatic model_edge();
      exp_err = 1'b0;
      if (!resetn) begin
         m_state = 0;
         q.delete();
      end else begin
         case (m_state)
            0: if (start && !stop) begin
                  if (letter < 26) begin
                     model_load(int'(letter));
                     m_state = 1;
                  end else begin
                     exp_err = 1'b1;
                  end
               end
            2: m_state = 0;
            default: begin
               if (stop) begin
                  m_state = 0;
                  q.delete();
               end else if (q.size() > 1) begin
                  void'(q.pop_front());
               end else if (in_gap) begin
                  if (letter < 26) begin
                     model_load(int'(letter));
                  end else begin
                     exp_err = 1'b1;
                     m_state = 0;
                     q.delete();
                  end
               end else if (rpt) begin
                  q.delete();
                  repeat (GAPU * DIV) q.push_back(1'b0);
                  in_gap = 1'b1;
               end else begin
                  m_state = 2;
                  q.delete();
               end
            end
         endcase
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      model_edge();
      #1;
      chk("led",  led,  (m_state == 1) && q.size() > 0 && q[0]);
      chk("busy", busy, m_state == 1);
      chk("done", done, m_state == 2);
      chk("err",  err,  exp_err);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic pulse(input int l);
      letter = l[4:0];
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      run(2);
      resetn = 1'b1;
      run(2);

      // Single-shot E, then A with an ignored start while busy.
      pulse(4);
      run(8);
      pulse(0);
      run(8);
      pulse(0);
      run(16);

      // Repeat E, switch to T, then drop repeat.
      rpt = 1'b1;
      pulse(4);
      run(20);
      letter = 5'd19;
      run(40);
      rpt = 1'b0;
      run(20);

      // Abort O mid-letter, then restart it.
      pulse(14);
      run(6);
      stop = 1'b1;
      step();
      stop = 1'b0;
      run(1);
      pulse(14);
      run(50);

      // Invalid letter, then Q.
      pulse(26);
      run(3);
      pulse(16);
      run(60);

      // Reset during the second dash of Q, then E.
      pulse(16);
      run(19);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      run(1);
      pulse(4);
      run(8);

      // Repeat with an invalid letter at the gap end.
      rpt = 1'b1;
      pulse(4);
      run(6);
      letter = 5'd30;
      run(20);
      rpt = 1'b0;

      for (int i = 0; i < 2500; i++) begin
         start  = ($urandom_range(0, 7) == 0);
         letter = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 99) == 0) rpt = ~rpt;
         stop   = ($urandom_range(0, 149) == 0);
         resetn = ($urandom_range(0, 399) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
